// File: rtl/max7219_chain_cmd_decod.sv
// Command sequencer for a daisy-chain of MAX7219 drivers: replays RAM words as 16-bit frames.
// Optional bounded loop count via MAX7219_CHAIN_DECOD_LOOP_CNT_EN (adds i_loop_nb).
module max7219_chain_cmd_decod #(
    parameter int unsigned G_RAM_ADDR_WIDTH    = 8,
    parameter int unsigned G_RAM_DATA_WIDTH    = 16,
    parameter int unsigned G_NB_MATRIX         = 8,
    parameter int unsigned G_DECOD_MAX_CNT_32B = 100
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_en,
    input  logic                        i_me,
    input  logic                        i_we,
    input  logic [G_RAM_ADDR_WIDTH-1:0] i_addr,
    input  logic [G_RAM_DATA_WIDTH-1:0] i_wdata,
    output logic [G_RAM_DATA_WIDTH-1:0] o_rdata,
    input  logic [G_RAM_ADDR_WIDTH-1:0] i_start_ptr,
    input  logic [G_RAM_ADDR_WIDTH-1:0] i_last_ptr,
    input  logic                        i_ptr_val,
    input  logic                        i_loop,
`ifdef MAX7219_CHAIN_DECOD_LOOP_CNT_EN
    input  logic [7:0]                  i_loop_nb,
`endif
    output logic                        o_ptr_equality,
    output logic                        o_discard,
    output logic                        o_busy,
    input  logic                        i_max7219_if_done,
    output logic                        o_max7219_if_start,
    output logic                        o_max7219_if_en_load,
    output logic [15:0]                 o_max7219_if_data
);

    localparam int unsigned DEPTH = 2 ** G_RAM_ADDR_WIDTH;
    localparam int unsigned GRP_W = 4;

    if (G_RAM_DATA_WIDTH < 16) begin : g_bad_data_width
        $error("G_RAM_DATA_WIDTH must be at least 16");
    end
    if (G_NB_MATRIX < 1 || G_NB_MATRIX > 16) begin : g_bad_nb_matrix
        $error("G_NB_MATRIX must be in 1..16");
    end

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StStart,
        StWaitDone,
        StNext,
        StDelay
    } state_e;

    state_e                      state_q, state_d;
    logic [G_RAM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [G_RAM_ADDR_WIDTH-1:0] start_q, start_d;
    logic [G_RAM_ADDR_WIDTH-1:0] last_q, last_d;
    logic                        loop_q, loop_d;
    logic [GRP_W-1:0]            grp_q, grp_d;
    logic [31:0]                 dly_q, dly_d;
    logic                        load_q, load_d;
    logic                        ptreq_q, ptreq_d;
    logic                        discard_q, discard_d;
    logic [G_RAM_DATA_WIDTH-1:0] rd_data_q;
    logic [G_RAM_DATA_WIDTH-1:0] rdata_q;
    logic                        accept;
    logic                        frame_load;
    logic                        loop_ok;

`ifdef MAX7219_CHAIN_DECOD_LOOP_CNT_EN
    logic [7:0]                  loop_nb_q, loop_nb_d;
    logic [7:0]                  pass_q, pass_d;
`endif

    logic [G_RAM_DATA_WIDTH-1:0] mem [DEPTH];

    // Port A: user access. Memory has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (i_me && i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (i_me && !i_we) begin
            rdata_q <= mem[i_addr];
        end
    end

    // Port B: sequencer read; a same-cycle port A write is seen on the next read only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (state_q == StRd) begin
            rd_data_q <= mem[ptr_q];
        end
    end

    assign accept = (state_q == StIdle) && i_ptr_val && i_en && (i_start_ptr <= i_last_ptr);
    assign frame_load = (grp_q == GRP_W'(G_NB_MATRIX - 1)) || (ptr_q == last_q);

`ifdef MAX7219_CHAIN_DECOD_LOOP_CNT_EN
    assign loop_ok = loop_q && i_loop && (pass_q != loop_nb_q);
`else
    assign loop_ok = loop_q && i_loop;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        start_d   = start_q;
        last_d    = last_q;
        loop_d    = loop_q;
        grp_d     = grp_q;
        dly_d     = dly_q;
        load_d    = load_q;
        ptreq_d   = 1'b0;
        discard_d = i_ptr_val && !accept;
`ifdef MAX7219_CHAIN_DECOD_LOOP_CNT_EN
        loop_nb_d = loop_nb_q;
        pass_d    = pass_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    start_d = i_start_ptr;
                    last_d  = i_last_ptr;
                    loop_d  = i_loop;
                    ptr_d   = i_start_ptr;
                    grp_d   = '0;
`ifdef MAX7219_CHAIN_DECOD_LOOP_CNT_EN
                    loop_nb_d = i_loop_nb;
                    pass_d    = '0;
`endif
                    state_d = StRd;
                end
            end
            StRd: begin
                state_d = i_en ? StStart : StIdle;
            end
            StStart: begin
                load_d  = frame_load;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (i_max7219_if_done) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                grp_d = load_q ? '0 : grp_q + GRP_W'(1);
                if (!i_en) begin
                    state_d = StIdle;
                end else if (load_q) begin
                    dly_d   = '0;
                    state_d = StDelay;
                end else begin
                    // Unloaded frame implies ptr < last, so no wrap here.
                    ptr_d   = ptr_q + G_RAM_ADDR_WIDTH'(1);
                    state_d = StRd;
                end
            end
            StDelay: begin
                if (!i_en) begin
                    state_d = StIdle;
                end else if (dly_q < G_DECOD_MAX_CNT_32B) begin
                    dly_d = dly_q + 32'd1;
                end else if (ptr_q < last_q) begin
                    ptr_d   = ptr_q + G_RAM_ADDR_WIDTH'(1);
                    state_d = StRd;
                end else if (loop_ok) begin
                    ptr_d   = start_q;
`ifdef MAX7219_CHAIN_DECOD_LOOP_CNT_EN
                    pass_d  = pass_q + 8'd1;
`endif
                    state_d = StRd;
                end else begin
                    ptreq_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            start_q   <= '0;
            last_q    <= '0;
            loop_q    <= 1'b0;
            grp_q     <= '0;
            dly_q     <= '0;
            load_q    <= 1'b0;
            ptreq_q   <= 1'b0;
            discard_q <= 1'b0;
`ifdef MAX7219_CHAIN_DECOD_LOOP_CNT_EN
            loop_nb_q <= '0;
            pass_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            start_q   <= start_d;
            last_q    <= last_d;
            loop_q    <= loop_d;
            grp_q     <= grp_d;
            dly_q     <= dly_d;
            load_q    <= load_d;
            ptreq_q   <= ptreq_d;
            discard_q <= discard_d;
`ifdef MAX7219_CHAIN_DECOD_LOOP_CNT_EN
            loop_nb_q <= loop_nb_d;
            pass_q    <= pass_d;
`endif
        end
    end

    assign o_rdata              = rdata_q;
    assign o_busy               = (state_q != StIdle);
    assign o_ptr_equality       = ptreq_q;
    assign o_discard            = discard_q;
    assign o_max7219_if_start   = (state_q == StStart);
    assign o_max7219_if_en_load = (state_q == StStart) && frame_load;
    assign o_max7219_if_data    = rd_data_q[15:0];

endmodule

// File: tb/tb_max7219_chain_cmd_decod.sv
// Scoreboard bench for max7219_chain_cmd_decod: a serialiser model pops expected frames per start.
module tb_max7219_chain_cmd_decod;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 16;
    localparam int unsigned NB  = 8;
    localparam int unsigned DLY = 100;

    typedef struct packed {
        logic [15:0] data;
        logic        load;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic          me = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic [AW-1:0] start_ptr = '0;
    logic [AW-1:0] last_ptr = '0;
    logic          ptr_val = 1'b0;
    logic          loop = 1'b0;
    logic          peq;
    logic          discard;
    logic          busy;
    logic          done = 1'b0;
    logic          start;
    logic          en_load;
    logic [15:0]   data;
`ifdef MAX7219_CHAIN_DECOD_LOOP_CNT_EN
    logic [7:0]    loop_nb = 8'd0;
`endif

    frame_t      exp_q[$];
    logic [15:0] mem_model [256];
    int total = 0;
    int bad = 0;
    int frames_seen = 0;
    int peq_cnt = 0;
    int disc_cnt = 0;
    int cyc = 0;
    int t_done = 0;
    int t_peq = 0;

    always #5 clk = ~clk;

    max7219_chain_cmd_decod #(
        .G_RAM_ADDR_WIDTH   (AW),
        .G_RAM_DATA_WIDTH   (DW),
        .G_NB_MATRIX        (NB),
        .G_DECOD_MAX_CNT_32B(DLY)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_en                (en),
        .i_me                (me),
        .i_we                (we),
        .i_addr              (addr),
        .i_wdata             (wdata),
        .o_rdata             (rdata),
        .i_start_ptr         (start_ptr),
        .i_last_ptr          (last_ptr),
        .i_ptr_val           (ptr_val),
        .i_loop              (loop),
`ifdef MAX7219_CHAIN_DECOD_LOOP_CNT_EN
        .i_loop_nb           (loop_nb),
`endif
        .o_ptr_equality      (peq),
        .o_discard           (discard),
        .o_busy              (busy),
        .i_max7219_if_done   (done),
        .o_max7219_if_start  (start),
        .o_max7219_if_en_load(en_load),
        .o_max7219_if_data   (data)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (peq) begin
                peq_cnt++;
                t_peq = cyc;
            end
            if (discard) disc_cnt++;
        end
    end

    // Serialiser model: checks each frame against the scoreboard, then answers with done.
    initial begin
        frame_t      e;
        logic [15:0] exp_data;
        forever begin
            @(negedge clk);
            if (start) begin
                frames_seen++;
                exp_data = 16'h0;
                if (exp_q.size() == 0) begin
                    check_val("extra_frame", 32'(frames_seen), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    exp_data = e.data;
                    check_val("frame_data", 32'(data), 32'(e.data));
                    check_val("frame_load", 32'(en_load), 32'(e.load));
                end
                @(negedge clk);
                check_val("start_width", 32'(start), 32'd0);
                repeat (2) @(posedge clk);
                #1;
                if (busy) check_val("data_held", 32'(data), 32'(exp_data));
                done = 1'b1;
                t_done = cyc;
                @(posedge clk);
                #1;
                done = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ram_write(input int a, input logic [15:0] d);
        tick();
        me = 1'b1;
        we = 1'b1;
        addr = AW'(a);
        wdata = d;
        mem_model[a] = d;
        tick();
        me = 1'b0;
        we = 1'b0;
    endtask

    task automatic ram_read(input int a);
        tick();
        me = 1'b1;
        we = 1'b0;
        addr = AW'(a);
        tick();
        me = 1'b0;
        check_val("ram_read", 32'(rdata), 32'(mem_model[a]));
    endtask

    // Expected frames for one pass from s to l, truncated to maxn frames.
    task automatic push_seq(input int s, input int l, input int maxn);
        int     g = 0;
        int     n = 0;
        frame_t f;
        for (int p = s; p <= l && n < maxn; p++) begin
            f.data = mem_model[p];
            f.load = (g == int'(NB) - 1) || (p == l);
            exp_q.push_back(f);
            g = f.load ? 0 : g + 1;
            n++;
        end
    endtask

    task automatic request(input int s, input int l, input logic lp);
        tick();
        start_ptr = AW'(s);
        last_ptr = AW'(l);
        loop = lp;
        ptr_val = 1'b1;
        tick();
        ptr_val = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check_val(tag, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_frames(input int target, input string tag);
        int n = 0;
        while (frames_seen < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check_val(tag, 32'(frames_seen), 32'(target));
    endtask

    initial begin
        int p0;
        int d0;
        int f0;
        int gap;

        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_peq", 32'(peq), 32'd0);
        check_val("rst_discard", 32'(discard), 32'd0);
        check_val("rst_start", 32'(start), 32'd0);
        check_val("rst_en_load", 32'(en_load), 32'd0);
        check_val("rst_data", 32'(data), 32'd0);
        check_val("rst_rdata", 32'(rdata), 32'd0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) ram_write(i, 16'(((i + 1) << 8) | 1));
        ram_write(254, 16'h5A5A);
        ram_write(255, 16'hBEEF);
        ram_read(3);
        ram_read(255);

        // Full group of 8, loaded on the last frame only.
        p0 = peq_cnt; d0 = disc_cnt; f0 = frames_seen;
        push_seq(0, 7, 99);
        request(0, 7, 1'b0);
        wait_idle("basic_timeout");
        check_val("basic_frames", 32'(frames_seen - f0), 32'd8);
        check_val("basic_peq", 32'(peq_cnt - p0), 32'd1);
        check_val("basic_discard", 32'(disc_cnt - d0), 32'd0);
        check_val("basic_queue", 32'(exp_q.size()), 32'd0);

        // Partial group flush and post-group delay.
        p0 = peq_cnt; f0 = frames_seen;
        push_seq(2, 4, 99);
        request(2, 4, 1'b0);
        wait_idle("partial_timeout");
        check_val("partial_frames", 32'(frames_seen - f0), 32'd3);
        check_val("partial_peq", 32'(peq_cnt - p0), 32'd1);
        gap = t_peq - t_done;
        check_val("partial_delay", 32'(gap >= int'(DLY) && gap <= int'(DLY) + 8), 32'd1);

        // Request while busy is discarded; sequence unaffected.
        p0 = peq_cnt; d0 = disc_cnt; f0 = frames_seen;
        push_seq(0, 7, 99);
        request(0, 7, 1'b0);
        wait_frames(f0 + 2, "busy_disc_timeout");
        request(5, 3, 1'b0);
        wait_idle("busy_disc_idle");
        check_val("busy_discard", 32'(disc_cnt - d0), 32'd1);
        check_val("busy_disc_frames", 32'(frames_seen - f0), 32'd8);
        check_val("busy_disc_peq", 32'(peq_cnt - p0), 32'd1);

        // Bad bounds and disabled sequencer in IDLE.
        d0 = disc_cnt; f0 = frames_seen;
        request(5, 3, 1'b0);
        repeat (5) tick();
        check_val("bounds_discard", 32'(disc_cnt - d0), 32'd1);
        check_val("bounds_busy", 32'(busy), 32'd0);
        en = 1'b0;
        request(0, 7, 1'b0);
        repeat (5) tick();
        check_val("en_discard", 32'(disc_cnt - d0), 32'd2);
        check_val("en_no_frames", 32'(frames_seen - f0), 32'd0);
        en = 1'b1;

        // Loop mode, dropped during pass 3.
        p0 = peq_cnt; f0 = frames_seen;
        for (int k = 0; k < 3; k++) push_seq(0, 1, 99);
        request(0, 1, 1'b1);
        wait_frames(f0 + 5, "loop_timeout");
        loop = 1'b0;
        wait_idle("loop_idle");
        check_val("loop_frames", 32'(frames_seen - f0), 32'd6);
        check_val("loop_peq", 32'(peq_cnt - p0), 32'd1);
        check_val("loop_queue", 32'(exp_q.size()), 32'd0);

        // Enable dropped at frame 3 of 8.
        p0 = peq_cnt; f0 = frames_seen;
        push_seq(0, 7, 3);
        request(0, 7, 1'b0);
        wait_frames(f0 + 3, "endrop_timeout");
        en = 1'b0;
        wait_idle("endrop_idle");
        repeat (20) tick();
        check_val("endrop_frames", 32'(frames_seen - f0), 32'd3);
        check_val("endrop_peq", 32'(peq_cnt - p0), 32'd0);
        en = 1'b1;

        // Reset mid-frame.
        f0 = frames_seen;
        push_seq(0, 7, 1);
        request(0, 7, 1'b0);
        wait_frames(f0 + 1, "rst_mid_timeout");
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_busy", 32'(busy), 32'd0);
        check_val("mid_start", 32'(start), 32'd0);
        check_val("mid_en_load", 32'(en_load), 32'd0);
        check_val("mid_data", 32'(data), 32'd0);
        check_val("mid_peq", 32'(peq), 32'd0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check_val("mid_no_restart", 32'(frames_seen - f0), 32'd1);
        check_val("mid_queue", 32'(exp_q.size()), 32'd0);
        ram_read(3);

        // Top of address space: no wrap past 255.
        p0 = peq_cnt; f0 = frames_seen;
        push_seq(254, 255, 99);
        request(254, 255, 1'b0);
        wait_idle("top_timeout");
        check_val("top_frames", 32'(frames_seen - f0), 32'd2);
        check_val("top_peq", 32'(peq_cnt - p0), 32'd1);

        // Single frame, start == last.
        p0 = peq_cnt; f0 = frames_seen;
        push_seq(5, 5, 99);
        request(5, 5, 1'b0);
        wait_idle("single_timeout");
        check_val("single_frames", 32'(frames_seen - f0), 32'd1);
        check_val("single_peq", 32'(peq_cnt - p0), 32'd1);

`ifdef MAX7219_CHAIN_DECOD_LOOP_CNT_EN
        p0 = peq_cnt; f0 = frames_seen;
        loop_nb = 8'd2;
        for (int k = 0; k < 3; k++) push_seq(0, 3, 99);
        request(0, 3, 1'b1);
        wait_idle("loopnb_timeout");
        check_val("loopnb_frames", 32'(frames_seen - f0), 32'd12);
        check_val("loopnb_peq", 32'(peq_cnt - p0), 32'd1);
        loop = 1'b0;
`endif

        check_val("final_queue", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
